pulse_cmd_fifo: RTL
===================

PULSE_CMD_FIFO -- requirements
Module: pulse_cmd_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of the FIFO entry count (16 entries).
REQ-002 SHALL have input clk, 1 bit: the RFSoC fabric clock; all logic is on its rising edge.
REQ-003 SHALL have input rst, 1 bit: reset, asynchronous, active-low; clock clk.
REQ-004 SHALL have input s_axis_tdata, 32 bits: a host command word ([31:24] command, [23:8] coarse, [7:0] fine).
REQ-005 SHALL have input s_axis_tvalid, 1 bit: the host word is valid.
REQ-006 SHALL have output s_axis_tready, 1 bit: the block can accept a word.
REQ-007 SHALL have output fifo_empty, 1 bit: no stored word is available to the pulse generator.
REQ-008 SHALL have output fifo_data, 32 bits: the head word (first-word-fall-through).
REQ-009 SHALL have input fifo_read, 1 bit: pops the head word.
REQ-010 SHALL have output level, DEPTH_LOG2+1 bits: the number of stored words.
REQ-011 SHALL have output drop_count, 16 bits: the number of rejected words.
REQ-012 SHALL have input clear_counts, 1 bit: a synchronous clear of drop_count.

Function
REQ-013 SHALL drive s_axis_tready = (level != 2^DEPTH_LOG2), combinationally from registered state only.
REQ-014 SHALL accept a word on a cycle where s_axis_tvalid && s_axis_tready.
REQ-015 SHALL make an accepted, stored word visible on fifo_data, with fifo_empty low, in the cycle after acceptance (1-cycle latency into an empty FIFO).
REQ-016 SHALL hold fifo_data at the current head word whenever fifo_empty is low; its value when empty is don't-care, but it SHALL be stable.
REQ-017 SHALL pop on fifo_read && !fifo_empty, so the next word (or empty) appears in the following cycle.
REQ-018 SHALL ignore fifo_read while fifo_empty is high, with no pointer or level change.
REQ-019 SHALL, on a simultaneous push and pop with the FIFO non-empty and non-full, leave level unchanged and advance both pointers.
REQ-020 SHALL, on a push while empty with fifo_read high, ignore the read; the word is stored and appears next cycle.
REQ-021 SHALL wrap the read and write pointers modulo 2^DEPTH_LOG2; level ranges from 0 to 2^DEPTH_LOG2.
REQ-022 SHALL, while full, hold s_axis_tready low, store nothing and leave drop_count unchanged (backpressure, no loss).
REQ-023 SHALL saturate drop_count at 16'hFFFF.
REQ-024 SHALL give clear_counts priority over a same-cycle increment, so drop_count becomes 0.
REQ-025 SHALL treat command codes 0=reset_clock, 1=send_pulse, 2=set_period, 3=set_phase_meas_mode and 4=reset_phase_meas_mode as valid.

Reset
REQ-026 SHALL, on rst low, immediately clear both pointers and level to 0 and drive fifo_empty=1, s_axis_tready=0 and drop_count=0.
REQ-027 SHALL drive s_axis_tready high from the first clk edge after rst is released.
REQ-028 SHALL, on reset mid-operation, discard all stored words; memory contents need not be cleared.

Configuration
REQ-029 SHALL, with PULSE_CMD_FILTER_EN defined, accept a word whose command code is >4, never store it, increment drop_count and keep s_axis_tready high (the word is consumed).
REQ-030 SHALL, without PULSE_CMD_FILTER_EN, store every accepted word unchanged and hold drop_count constant at 0.

Structure
REQ-031 SHALL place the command-code constants (0..4), the maximum valid code and the command-word field positions in shared package pulse_pkg, which pulse_gen also uses.
REQ-032 SHALL implement storage, pointers and level in sub-module sync_fifo_fwft (parameters WIDTH, DEPTH_LOG2); pulse_cmd_fifo adds the AXIS handshake, the filter and the counters.

Verification
REQ-033 SHALL verify: push 0x01000305 into an empty FIFO -> next cycle fifo_empty=0, fifo_data=0x01000305, level=1; pulse fifo_read -> fifo_empty=1, level=0.
REQ-034 SHALL verify: push 16 words 0x02000000..0x0200000F with no reads -> s_axis_tready=0 at level=16; a 17th word is held; one pop -> tready=1 and the 17th word is accepted; readout order is 0..F then the 17th word.
REQ-035 SHALL verify: at level=5, push and pop on the same cycle for 10 cycles -> level stays 5, data in order, pointers wrap cleanly.
REQ-036 SHALL verify, with the filter enabled: push 0x05000000 and 0xFF123456 -> level stays 0, drop_count=2; assert clear_counts in the same cycle as a third bad word -> drop_count=0.
REQ-037 SHALL verify: assert rst low at level=7 mid-stream -> fifo_empty=1, level=0, drop_count=0 immediately; after release a new word 0x03000000 is the first word read.
REQ-038 SHALL verify: hold fifo_read high while empty, then push 0x04000000 -> the word appears and is not popped on the push cycle.

Source files
------------

// File: rtl/pulse_pkg.sv
// Pulse command definitions shared by pulse_cmd_fifo and pulse_gen:
// command codes, highest valid code and the command-word layout.
package pulse_pkg;

  localparam int CMD_WORD_W = 32;
  localparam int CMD_MSB    = 31;
  localparam int CMD_LSB    = 24;

  typedef enum logic [7:0] {
    CMD_RESET_CLOCK           = 8'd0,
    CMD_SEND_PULSE            = 8'd1,
    CMD_SET_PERIOD            = 8'd2,
    CMD_SET_PHASE_MEAS_MODE   = 8'd3,
    CMD_RESET_PHASE_MEAS_MODE = 8'd4
  } cmd_e;

  localparam logic [7:0] CMD_MAX_VALID = 8'd4;

  // Bit layout of a host command word, MSB first
  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] coarse;
    logic [7:0]  fine;
  } cmd_word_t;

  function automatic logic cmd_is_valid(input logic [7:0] code);
    return (code <= CMD_MAX_VALID);
  endfunction

endpackage

// File: rtl/pulse_cmd_fifo_if.sv
// Host AXIS write side and pulse-generator FWFT read side of the command FIFO.
// slave is the FIFO's view; master is the host / pulse generator view.
interface pulse_cmd_fifo_if;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_read;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output fifo_empty,
    output fifo_data,
    input  fifo_read
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  fifo_empty,
    input  fifo_data,
    output fifo_read
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: storage, wrapping pointers and level.
// Pops are ignored while empty and pushes while full.
module sync_fifo_fwft #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic                  empty,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int                    DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic                  push_s;
  logic                  pop_s;

  assign full    = (level_r == LEVEL_FULL);
  assign empty   = (level_r == {(DEPTH_LOG2+1){1'b0}});
  assign push_s  = wr_en & ~full;
  assign pop_s   = rd_en & ~empty;
  // Head word is read straight from storage; it only moves on a pop
  assign rd_data = mem_r[rd_ptr_r];
  assign level   = level_r;

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH_LOG2 bits; level tracks occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      level_r  <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end
endmodule

// File: rtl/pulse_cmd_fifo.sv
// Host command FIFO feeding the pulse generator: AXIS slave in, FWFT out, drop counter.
// Define PULSE_CMD_FILTER_EN to consume and count words whose command code is unknown.
module pulse_cmd_fifo
  import pulse_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  pulse_cmd_fifo_if.slave     bus,
  output logic [DEPTH_LOG2:0] level,
  output logic [15:0]         drop_count,
  input  logic                clear_counts
);
  logic        ready_en_r;
  logic        full_s;
  logic        accept_s;
  logic        cmd_ok_s;
  logic        store_s;
  logic        drop_s;
  logic [15:0] drop_count_r;

  // Ready is withheld until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  assign bus.s_axis_tready = ready_en_r & ~full_s;
  assign accept_s          = bus.s_axis_tvalid & bus.s_axis_tready;

`ifdef PULSE_CMD_FILTER_EN
  assign cmd_ok_s = cmd_is_valid(bus.s_axis_tdata[CMD_MSB:CMD_LSB]);
`else
  assign cmd_ok_s = 1'b1;
`endif

  // Split an accepted word into "store" or "consume and count"
  always_comb begin
    store_s = 1'b0;
    drop_s  = 1'b0;
    if (accept_s) begin
      store_s = cmd_ok_s;
      drop_s  = ~cmd_ok_s;
    end else begin
      store_s = 1'b0;
      drop_s  = 1'b0;
    end
  end

  // Saturating drop counter; clear wins over a same-cycle drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count_r <= 16'd0;
    end else if (clear_counts) begin
      drop_count_r <= 16'd0;
    end else if (drop_s && (drop_count_r != 16'hFFFF)) begin
      drop_count_r <= drop_count_r + 16'd1;
    end else begin
      drop_count_r <= drop_count_r;
    end
  end

  assign drop_count = drop_count_r;

  sync_fifo_fwft #(
    .WIDTH      (CMD_WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (store_s),
    .wr_data (bus.s_axis_tdata),
    .full    (full_s),
    .rd_en   (bus.fifo_read),
    .empty   (bus.fifo_empty),
    .rd_data (bus.fifo_data),
    .level   (level)
  );
endmodule
